// File: rtl/cmp_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// The result triple is one-hot whenever it qualifies a valid compare.
package cmp_pkg;

   localparam int DEFAULT_WIDTH     = 4;
   localparam int DEFAULT_CASCADE_W = 4;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_res_t;

   localparam cmp_res_t RES_EQ = 3'b100;
   localparam cmp_res_t RES_GT = 3'b010;
   localparam cmp_res_t RES_LT = 3'b001;

endpackage

// File: rtl/cmp_slice.sv
// Combinational CASCADE_W-bit magnitude compare with cascade in/out.
// An upstream decision (not eq) passes straight through; otherwise the first differing bit decides.
module cmp_slice
   import cmp_pkg::*;
#(
   parameter int CASCADE_W = DEFAULT_CASCADE_W
) (
   input  logic [CASCADE_W-1:0] a_i,
   input  logic [CASCADE_W-1:0] b_i,
   input  cmp_res_t             casc_i,
   output cmp_res_t             casc_o
);

   cmp_res_t res;

   always_comb begin
      res = casc_i;
      if (casc_i.eq) begin
         res = RES_EQ;
         for (int k = CASCADE_W - 1; k >= 0; k--) begin
            if (res.eq && (a_i[k] != b_i[k])) begin
               res = a_i[k] ? RES_GT : RES_LT;
            end
         end
      end
   end

   assign casc_o = res;

endmodule

// File: rtl/mag_comparator.sv
// Registered magnitude comparator: one-hot eq/gt/lt one cycle after in_valid,
// with optional two's-complement ordering selected per transaction.
module mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int CASCADE_W = DEFAULT_CASCADE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int NSLICE = WIDTH / CASCADE_W;

   if ((WIDTH < 1) || (WIDTH > 32) || ((WIDTH % CASCADE_W) != 0)) begin : g_bad_cfg
      $error("mag_comparator: WIDTH must be 1..32 and a multiple of CASCADE_W");
   end

   logic [WIDTH-1:0] a_adj;
   logic [WIDTH-1:0] b_adj;
   cmp_res_t         res_d;
   cmp_res_t         res_q;
   logic             valid_q;

   // Inverting both sign bits maps two's-complement order onto unsigned order; eq is unaffected.
   always_comb begin
      a_adj = a;
      b_adj = b;
      if (signed_mode) begin
         a_adj[WIDTH-1] = ~a[WIDTH-1];
         b_adj[WIDTH-1] = ~b[WIDTH-1];
      end
   end

   for (genvar i = 0; i < NSLICE; i++) begin : g_slice
      cmp_res_t casc_in;
      cmp_res_t casc_out;

      if (i == NSLICE - 1) begin : g_seed
         assign casc_in = RES_EQ;
      end else begin : g_link
         assign casc_in = g_slice[i+1].casc_out;
      end

      cmp_slice #(
         .CASCADE_W (CASCADE_W)
      ) u_slice (
         .a_i    (a_adj[i*CASCADE_W +: CASCADE_W]),
         .b_i    (b_adj[i*CASCADE_W +: CASCADE_W]),
         .casc_i (casc_in),
         .casc_o (casc_out)
      );
   end

   assign res_d = g_slice[0].casc_out;

   // Flags hold across idle cycles; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         res_q   <= '0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            res_q <= res_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign eq        = res_q.eq;
   assign gt        = res_q.gt;
   assign lt        = res_q.lt;

endmodule

// File: tb/tb_mag_comparator.sv
// Scoreboard bench for mag_comparator: the driver pushes reference results,
// a negedge monitor pops and checks them against the DUT.
module tb_mag_comparator;
   import cmp_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         signed_mode;
   logic         out_valid;
   logic         eq;
   logic         gt;
   logic         lt;

   int n_cmp = 0;
   int n_bad = 0;

   cmp_res_t exp_q[$];
   logic     exp_valid = 1'b0;
   logic     exp_clear = 1'b1;
   cmp_res_t hold_flags = '0;

   always #5 clk = ~clk;

   mag_comparator #(.WIDTH(W), .CASCADE_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .eq          (eq),
      .gt          (gt),
      .lt          (lt)
   );

   function automatic cmp_res_t ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic sm);
      int vx;
      int vy;
      vx = int'(x);
      vy = int'(y);
      if (sm) begin
         if (vx >= (1 << (W - 1))) vx = vx - (1 << W);
         if (vy >= (1 << (W - 1))) vy = vy - (1 << W);
      end
      if (vx == vy) return RES_EQ;
      if (vx > vy)  return RES_GT;
      return RES_LT;
   endfunction

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle; the expectation is recorded on the edge that samples it.
   task automatic drive(input logic r, input logic v, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic sm);
      rst         = r;
      in_valid    = v;
      a           = xa;
      b           = xb;
      signed_mode = sm;
      @(posedge clk);
      exp_valid = v && !r;
      exp_clear = r;
      if (v && !r) exp_q.push_back(ref_cmp(xa, xb, sm));
      #1;
   endtask

   initial begin : monitor
      cmp_res_t got;
      cmp_res_t want;
      forever begin
         @(negedge clk);
         got = {eq, gt, lt};
         check("out_valid", {2'b00, out_valid}, {2'b00, exp_valid});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 3'b001, 3'b000);
            end else begin
               want = exp_q.pop_front();
               check("flags", got, want);
               check("onehot", {2'b00, $onehot(got)}, 3'b001);
               hold_flags = want;
            end
         end else begin
            if (exp_clear) hold_flags = '0;
            check(exp_clear ? "reset_flags" : "hold_flags", got, hold_flags);
         end
      end
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sm;
   } vec_t;

   vec_t dir_vecs[$] = '{
      '{4'b0000, 4'b0000, 1'b0}, '{4'b0001, 4'b0010, 1'b0}, '{4'b0010, 4'b0001, 1'b0},
      '{4'b0011, 4'b0011, 1'b0}, '{4'b0100, 4'b0101, 1'b0}, '{4'b0101, 4'b0100, 1'b0},
      '{4'b0110, 4'b0110, 1'b0}, '{4'b0111, 4'b1000, 1'b0}, '{4'b1000, 4'b0111, 1'b0},
      '{4'b1001, 4'b1001, 1'b0}, '{4'b1010, 4'b1011, 1'b0}, '{4'b1011, 4'b1010, 1'b0},
      '{4'b0100, 4'b1000, 1'b0}, '{4'b1111, 4'b0000, 1'b0}, '{4'b1111, 4'b1111, 1'b0},
      '{4'b0111, 4'b1000, 1'b1}, '{4'b1000, 4'b0111, 1'b1}, '{4'b1111, 4'b0000, 1'b1},
      '{4'b1110, 4'b1111, 1'b1}, '{4'b1010, 4'b1010, 1'b1}, '{4'b0000, 4'b0000, 1'b1}
   };

   initial begin : driver
      rst = 1'b1; in_valid = 1'b1; a = 4'b0011; b = 4'b0011; signed_mode = 1'b0;

      drive(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0);
      drive(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0);

      foreach (dir_vecs[i]) drive(1'b0, 1'b1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].sm);

      drive(1'b0, 1'b1, 4'b0001, 4'b0010, 1'b0);
      drive(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
      drive(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
      drive(1'b0, 1'b1, 4'b0010, 4'b0001, 1'b0);

      drive(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
      drive(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b0);
      drive(1'b1, 1'b1, 4'b1100, 4'b0001, 1'b0);
      drive(1'b0, 1'b1, 4'b1100, 4'b0001, 1'b1);
      drive(1'b0, 1'b1, 4'b0110, 4'b0110, 1'b0);
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

      for (int m = 0; m < 2; m++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               drive(1'b0, 1'b1, W'(x), W'(y), m[0]);

      for (int n = 0; n < 300; n++)
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
               W'($urandom), W'($urandom), 1'($urandom));

      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      @(negedge clk);
      check("queue_drained", exp_q.size() == 0 ? 3'b000 : 3'b001, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
